// File: rtl/axi_slv_mem_rsp.sv
// AXI4 slave memory responder.
// Accepts full-width write bursts into an internal word array, returns one write
// response per burst and serves full-width read bursts from the same array. The
// write and read directions each run their own FSM with one transaction in flight.
//
// Ports:
//   aclk, aresetn                          clock, asynchronous active-low reset
//   awid/awaddr/awlen/awburst/awvalid/awready  write address channel
//   wdata/wstrb/wlast/wvalid/wready        write data channel
//   bid/bresp/bvalid/bready                write response channel
//   arid/araddr/arlen/arburst/arvalid/arready  read address channel
//   rid/rdata/rresp/rlast/rvalid/rready    read data channel
module axi_slv_mem_rsp #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] BURST_RSVD = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Byte size of a wrap block minus one, i.e. the in-block offset mask.
    function automatic logic [ADDR_WIDTH-1:0] wrap_mask(input logic [7:0] len);
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << BYTE_SHIFT) - ADDR_WIDTH'(1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0]            len,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = addr + ADDR_WIDTH'(STRB_WIDTH);
        mask = wrap_mask(len);
        case (burst)
            BURST_INCR: next_addr = inc;
            BURST_WRAP: next_addr = (addr & ~mask) | (inc & mask);
            default:    next_addr = addr;
        endcase
    endfunction

    function automatic logic burst_illegal(input logic [ADDR_WIDTH-1:0] addr,
                                           input logic [7:0]            len,
                                           input logic [1:0]            burst);
        burst_illegal = 1'b0;
        if (burst == BURST_RSVD) begin
            burst_illegal = 1'b1;
        end else if (burst == BURST_WRAP) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
                burst_illegal = 1'b1;
            end else if ((addr & ADDR_WIDTH'(STRB_WIDTH - 1)) != '0) begin
                burst_illegal = 1'b1;
            end
        end
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        in_range = (addr >> BYTE_SHIFT) < ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] w;
        w        = addr >> BYTE_SHIFT;
        word_idx = w[IDX_WIDTH-1:0];
    endfunction

    // ---------------------------------------------------------------- write side
    logic [1:0]            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic                  w_bad_q, w_bad_d;
    logic                  w_slv_q, w_slv_d;
    logic                  w_dec_q, w_dec_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  w_final;
    logic                  mem_we;

    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        w_bad_d   = w_bad_q;
        w_slv_d   = w_slv_q;
        w_dec_d   = w_dec_q;
        bresp_d   = bresp_q;
        w_final   = (wcnt_q == wlen_q);
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    bid_d     = awid;
                    waddr_d   = awaddr;
                    wlen_d    = awlen;
                    wburst_d  = awburst;
                    w_bad_d   = burst_illegal(awaddr, awlen, awburst);
                    wcnt_d    = '0;
                    w_slv_d   = 1'b0;
                    w_dec_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    if (wlast != w_final) begin
                        w_slv_d = 1'b1;
                    end
                    // Illegal bursts never touch the array; out-of-range beats are dropped.
                    if (!w_bad_q) begin
                        if (in_range(waddr_q)) begin
                            mem_we = 1'b1;
                        end else begin
                            w_dec_d = 1'b1;
                        end
                    end
                    waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    if (w_final) begin
                        w_state_d = W_RESP;
                        if (w_bad_q) begin
                            bresp_d = RESP_SLVERR;
                        end else if (w_dec_d) begin
                            bresp_d = RESP_DECERR;
                        end else if (w_slv_d) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            bresp_d = RESP_OKAY;
                        end
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = bid_q;
    assign bresp   = bresp_q;

    // The array has no reset; contents survive aresetn.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read side
    logic [0:0]            r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;   // address of the next beat to fetch
    logic [7:0]            rlen_q, rlen_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  r_bad_q, r_bad_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  ar_bad;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_bad;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic [1:0]            fetch_resp;

    assign ar_bad = burst_illegal(araddr, arlen, arburst);

    // One array read port serves both the first beat (from AR) and later beats.
    always_comb begin
        fetch_addr = (r_state_q == R_IDLE) ? araddr : raddr_q;
        fetch_bad  = (r_state_q == R_IDLE) ? ar_bad : r_bad_q;
        fetch_data = '0;
        fetch_resp = RESP_OKAY;
        if (fetch_bad) begin
            fetch_resp = RESP_SLVERR;
        end else if (!in_range(fetch_addr)) begin
            fetch_resp = RESP_DECERR;
        end else begin
            fetch_data = mem[word_idx(fetch_addr)];
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        r_bad_d   = r_bad_q;
        rcnt_d    = rcnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rid_d     = arid;
                    rlen_d    = arlen;
                    rburst_d  = arburst;
                    r_bad_d   = ar_bad;
                    rcnt_d    = '0;
                    rdata_d   = fetch_data;
                    rresp_d   = fetch_resp;
                    rlast_d   = (arlen == 8'd0);
                    raddr_d   = next_addr(araddr, arlen, arburst);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        rcnt_d  = rcnt_q + 8'd1;
                        rdata_d = fetch_data;
                        rresp_d = fetch_resp;
                        rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                        raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            w_bad_q   <= 1'b0;
            w_slv_q   <= 1'b0;
            w_dec_q   <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            r_bad_q   <= 1'b0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            bid_q     <= bid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            w_bad_q   <= w_bad_d;
            w_slv_q   <= w_slv_d;
            w_dec_q   <= w_dec_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            r_bad_q   <= r_bad_d;
            rcnt_q    <= rcnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

endmodule

// File: tb/tb_axi_slv_mem_rsp.sv
// Self-checking bench for axi_slv_mem_rsp: directed bursts plus randomized traffic,
// compared every cycle against a burst-level model of the word array.
module tb_axi_slv_mem_rsp;

    localparam int DEPTH = 256;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  wstrb;

    axi_slv_mem_rsp #(
        .ID_WIDTH   (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awid    (awid),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awburst (awburst),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .arid    (arid),
        .araddr  (araddr),
        .arlen   (arlen),
        .arburst (arburst),
        .arvalid (arvalid),
        .arready (arready),
        .rid     (rid),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bbeat_t;

    int          checks = 0;
    int          errors = 0;
    rbeat_t      exp_r[$];
    bbeat_t      exp_b[$];
    logic [31:0] mem_m [DEPTH];
    logic [31:0] wd_buf [256];
    logic [3:0]  ws_buf [256];
    logic        wl_buf [256];
    logic        r_stall = 1'b0;
    logic        b_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    function automatic int unsigned beat_addr(input int unsigned addr, input int unsigned len,
                                              input int unsigned burst, input int unsigned i);
        int unsigned size;
        int unsigned base;
        case (burst)
            1: return addr + 4 * i;
            2: begin
                size = (len + 1) * 4;
                base = addr - (addr % size);
                return base + ((addr - base + 4 * i) % size);
            end
            default: return addr;
        endcase
    endfunction

    function automatic bit is_illegal(input int unsigned addr, input int unsigned len,
                                      input int unsigned burst);
        if (burst == 3) return 1'b1;
        if (burst == 2) begin
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
            return (addr % 4) != 0;
        end
        return 1'b0;
    endfunction

    task automatic push_read_exp(input logic [3:0] id, input int unsigned addr,
                                 input int unsigned len, input int unsigned burst);
        int unsigned a;
        rbeat_t      e;
        for (int unsigned i = 0; i <= len; i++) begin
            a      = beat_addr(addr, len, burst, i);
            e.id   = id;
            e.last = (i == len);
            if (is_illegal(addr, len, burst)) begin
                e.data = 32'h0;
                e.resp = 2'b10;
            end else if (a / 4 >= DEPTH) begin
                e.data = 32'h0;
                e.resp = 2'b11;
            end else begin
                e.data = mem_m[a / 4];
                e.resp = 2'b00;
            end
            exp_r.push_back(e);
        end
    endtask

    // --------------------------------------------------- per-cycle comparison
    always @(negedge aclk) begin
        if (!aresetn) begin
            r_stall <= 1'b0;
            b_stall <= 1'b0;
        end else begin
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got rvalid=1 expected rvalid=0");
                end else begin
                    check("r_beat", {rid, rdata, rresp, rlast}, exp_r[0]);
                    if (rready) void'(exp_r.pop_front());
                end
            end else begin
                check("rlast_idle", rlast, 1'b0);
                if (r_stall) check("r_stall_drop", rvalid, 1'b1);
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got bvalid=1 expected bvalid=0");
                end else begin
                    check("b_resp", {bid, bresp}, exp_b[0]);
                    if (bready) void'(exp_b.pop_front());
                end
            end else if (b_stall) begin
                check("b_stall_drop", bvalid, 1'b1);
            end
            r_stall <= rvalid && !rready;
            b_stall <= bvalid && !bready;
        end
    end

    // --------------------------------------------------------------- drivers
    function automatic logic sig_hi(input int which);
        case (which)
            0:       return awready;
            1:       return wready;
            2:       return arready;
            default: return bvalid;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string name);
        int g;
        g = 0;
        @(negedge aclk);
        while (!sig_hi(which) && g < 500) begin
            @(negedge aclk);
            g++;
        end
        if (g >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got 0 expected 1", name);
        end
    endtask

    // Called at posedge+1; uses wd_buf/ws_buf/wl_buf for the beats.
    task automatic do_write(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                            input logic [1:0] burst, input int unsigned bdelay,
                            output logic [1:0] mresp);
        int unsigned a;
        bit          ill, dec, slv;
        bbeat_t      e;
        ill = is_illegal(addr, len, burst);
        dec = 1'b0;
        slv = 1'b0;
        for (int unsigned i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i);
            if (wl_buf[i] != (i == len)) slv = 1'b1;
            if (!ill) begin
                if (a / 4 < DEPTH) begin
                    for (int b = 0; b < 4; b++)
                        if (ws_buf[i][b]) mem_m[a / 4][8*b +: 8] = wd_buf[i][8*b +: 8];
                end else begin
                    dec = 1'b1;
                end
            end
        end
        mresp = ill ? 2'b10 : dec ? 2'b11 : slv ? 2'b10 : 2'b00;
        e.id   = id;
        e.resp = mresp;
        exp_b.push_back(e);

        awid    = id;
        awaddr  = addr;
        awlen   = 8'(len);
        awburst = burst;
        awvalid = 1'b1;
        wait_sig(0, "aw");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int unsigned i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge aclk); #1;
            end
            wvalid = 1'b1;
            wdata  = wd_buf[i];
            wstrb  = ws_buf[i];
            wlast  = wl_buf[i];
            wait_sig(1, "w");
            @(posedge aclk); #1;
            wvalid = 1'b0;
            wlast  = 1'b0;
        end
        repeat (bdelay) begin
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        wait_sig(3, "b");
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    // Called at posedge+1; returns the number of cycles the R beats took to drain.
    task automatic do_read(input logic [3:0] id, input int unsigned addr, input int unsigned len,
                           input logic [1:0] burst, input int unsigned rprob, output int cyc);
        push_read_exp(id, addr, len, burst);
        arid    = id;
        araddr  = addr;
        arlen   = 8'(len);
        arburst = burst;
        arvalid = 1'b1;
        wait_sig(2, "ar");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        @(negedge aclk);
        check("ar_to_r_latency", rvalid, 1'b1);
        @(posedge aclk); #1;
        cyc = 0;
        while (exp_r.size() != 0 && cyc < 2000) begin
            rready = ($urandom_range(0, 99) < rprob);
            @(posedge aclk); #1;
            cyc++;
        end
        rready = 1'b0;
        if (cyc >= 2000) begin
            checks++;
            errors++;
            $display("FAIL r_drain_timeout: got %0d beats left expected 0", exp_r.size());
            exp_r.delete();
        end
    endtask

    task automatic fill_wbuf(input int unsigned len, input bit rnd_strb, input bit bad_last);
        int unsigned flip;
        flip = $urandom_range(0, len);
        for (int unsigned i = 0; i <= len; i++) begin
            wd_buf[i] = $urandom;
            ws_buf[i] = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF;
            wl_buf[i] = (i == len);
            if (bad_last && i == flip) wl_buf[i] = ~wl_buf[i];
        end
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        logic [1:0]  mr;
        int          cyc;
        int unsigned addr, len, idx, sel;
        logic [1:0]  burst;
        logic [31:0] old_w, new_w;

        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awready", awready, 1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_wready", wready, 1'b0);
        check("rst_valids", {bvalid, rvalid, rlast}, 3'b000);
        check("rst_payload", {bresp, rresp, bid, rid, rdata}, 44'h0);
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;

        // Give the whole array a known value.
        fill_wbuf(255, 1'b0, 1'b0);
        do_write(4'h1, 0, 255, 2'b01, 0, mr);
        check("init_model_resp", mr, 2'b00);

        // INCR write of A0..A3 at 0x10, read back with rready held high.
        for (int i = 0; i < 4; i++) begin
            wd_buf[i] = 32'hA0 + i;
            ws_buf[i] = 4'hF;
            wl_buf[i] = (i == 3);
        end
        do_write(4'h3, 32'h10, 3, 2'b01, 1, mr);
        check("incr_model_resp", mr, 2'b00);
        check("model_word4", mem_m[4], 32'hA0);
        check("model_word7", mem_m[7], 32'hA3);
        do_read(4'h4, 32'h10, 3, 2'b01, 100, cyc);
        check("incr_no_bubble_cycles", cyc, 4);

        // WRAP read starting mid-block, then the same with an illegal length.
        check("wrap_addr1", beat_addr(32'h18, 3, 2, 1), 32'h1C);
        check("wrap_addr2", beat_addr(32'h18, 3, 2, 2), 32'h10);
        check("wrap_addr3", beat_addr(32'h18, 3, 2, 3), 32'h14);
        check("wrap_len2_illegal", is_illegal(32'h18, 2, 2), 1'b1);
        check("wrap_unaligned_illegal", is_illegal(32'h19, 3, 2), 1'b1);
        do_read(4'h5, 32'h18, 3, 2'b10, 70, cyc);
        do_read(4'h6, 32'h18, 2, 2'b10, 70, cyc);

        // Strobed write over all-ones with an early wlast and a stalled B.
        wd_buf[0] = 32'hFFFF_FFFF; ws_buf[0] = 4'hF; wl_buf[0] = 1'b1;
        do_write(4'h7, 32'h40, 0, 2'b01, 0, mr);
        wd_buf[0] = 32'h1122_3344; ws_buf[0] = 4'b0101; wl_buf[0] = 1'b1;
        wd_buf[1] = 32'h5566_7788; ws_buf[1] = 4'b0000; wl_buf[1] = 1'b1;
        do_write(4'h9, 32'h40, 1, 2'b01, 5, mr);
        check("strb_model_word", mem_m[16], 32'hFF22_FF44);
        check("early_wlast_model_resp", mr, 2'b10);
        do_read(4'hA, 32'h40, 0, 2'b01, 50, cyc);

        // Burst running off the top of the array.
        fill_wbuf(1, 1'b0, 1'b0);
        do_write(4'hB, DEPTH * 4 - 4, 1, 2'b01, 2, mr);
        check("oor_model_resp", mr, 2'b11);
        do_read(4'hC, DEPTH * 4 - 4, 1, 2'b01, 60, cyc);

        // Read capture and write on the same edge to the same word.
        old_w = mem_m[32];
        new_w = ~old_w;
        exp_b.push_back('{id: 4'h5, resp: 2'b00});
        exp_r.push_back('{id: 4'h6, data: old_w, resp: 2'b00, last: 1'b1});
        awid = 4'h5; awaddr = 32'h80; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
        wait_sig(0, "aw_same");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = new_w; wstrb = 4'hF; wlast = 1'b1;
        arvalid = 1'b1; arid = 4'h6; araddr = 32'h80; arlen = 8'd0; arburst = 2'b01;
        @(negedge aclk);
        check("same_edge_ready", {wready, arready}, 2'b11);
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        mem_m[32] = new_w;
        rready = 1'b1; bready = 1'b1;
        repeat (4) begin
            @(posedge aclk); #1;
        end
        rready = 1'b0; bready = 1'b0;
        check("same_edge_drained", exp_r.size() + exp_b.size(), 0);
        do_read(4'h7, 32'h80, 0, 2'b01, 100, cyc);

        // Reset in the middle of a stalled read burst.
        push_read_exp(4'h2, 32'h10, 3, 1);
        arid = 4'h2; araddr = 32'h10; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
        wait_sig(2, "ar_rst");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        repeat (3) @(negedge aclk);
        #2 aresetn = 1'b0;
        exp_r.delete();
        #1;
        check("async_rst_rvalid", rvalid, 1'b0);
        check("async_rst_ready", {arready, awready}, 2'b11);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            check("no_r_after_rst", rvalid, 1'b0);
        end
        @(posedge aclk); #1;
        rready = 1'b0;
        do_read(4'h8, 32'h10, 3, 2'b01, 80, cyc);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 9);
            burst = (sel == 0) ? 2'b00 : (sel <= 5) ? 2'b01 : (sel <= 8) ? 2'b10 : 2'b11;
            len = $urandom_range(0, 15);
            if (burst == 2'b10 && $urandom_range(0, 99) < 85) begin
                sel = $urandom_range(0, 3);
                len = (sel == 0) ? 1 : (sel == 1) ? 3 : (sel == 2) ? 7 : 15;
            end
            idx = ($urandom_range(0, 9) != 0) ? $urandom_range(0, DEPTH - 1)
                                               : $urandom_range(DEPTH - 4, DEPTH + 8);
            addr = idx * 4;
            if (burst == 2'b10 && $urandom_range(0, 9) == 0) addr += $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                fill_wbuf(len, 1'b1, $urandom_range(0, 9) == 0);
                do_write(4'($urandom), addr, len, burst, $urandom_range(0, 3), mr);
            end else begin
                do_read(4'($urandom), addr, len, burst, $urandom_range(30, 100), cyc);
            end
        end

        repeat (3) @(posedge aclk);
        check("end_queues_empty", exp_r.size() + exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_slv_mem_rsp.md
Name:
axi_slv_mem_rsp

Overview:
Synthesizable AXI4 slave memory responder: the responding end for the slave-side driver/monitor bench, usable as a DUT-side target behind the interconnect. It accepts write bursts into an internal word array, returns write responses, and serves read bursts from the same array. Each direction has its own FSM, with one outstanding transaction per direction.

Parameters:
ID_WIDTH, 4, width of awid/bid/arid/rid
ADDR_WIDTH, 32, byte address width (`SV_ADDR_WIDTH)
DATA_WIDTH, 32, data bus width (`SV_DATA_WIDTH), power of 2 and at least 8
MEM_DEPTH, 256, number of DATA_WIDTH words in the array

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
awid  in  ID_WIDTH  write id
awaddr  in  ADDR_WIDTH  write start byte address
awlen  in  8  beats minus 1
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  response id (= captured awid)
bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
bvalid  out  1  B valid
bready  in  1  B ready
arid  in  ID_WIDTH  read id
araddr  in  ADDR_WIDTH  read start byte address
arlen  in  8  beats minus 1
arburst  in  2  burst type, same encoding as awburst
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  ID_WIDTH  read id (= captured arid)
rdata  out  DATA_WIDTH  read data
rresp  out  2  per-beat response
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready

Behaviour:
- Reset (async, active-low): awready=1, arready=1. wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid and rdata all 0. Both FSMs go to IDLE. The array is not cleared. Reset mid-burst abandons the burst; beats already written stay written.
- Transfers are full-width only; size is implied as DATA_WIDTH/8 bytes. Word index = addr >> log2(DATA_WIDTH/8). A beat is in range when index < MEM_DEPTH.
- Next address: FIXED keeps the address. INCR adds DATA_WIDTH/8. WRAP increments within a block of (len+1)*DATA_WIDTH/8 bytes, aligned to that size. WRAP requires len in {1,3,7,15}.
- A burst is illegal if the burst type is 11, or if it is WRAP with any other len, or if it is WRAP with an unaligned start address. An illegal burst writes nothing and responds SLVERR on every beat.
- Write FSM, W_IDLE: awready=1. An AW handshake captures id, address, len and burst, and moves to W_DATA.
- Write FSM, W_DATA: wready=1. Each W handshake writes only the strobed bytes, advances the address and counts the beat.
- Write FSM, end of burst: on the beat whose count equals awlen, go to W_RESP. If wlast does not match the final-beat flag on any beat, the burst is flagged SLVERR; the beat count still governs termination.
- Write FSM, W_RESP: bvalid=1 until bready, then back to W_IDLE. Response priority: DECERR (any beat out of range, and that beat is not written), then SLVERR, then OKAY.
- Read FSM, R_IDLE: arready=1. An AR handshake captures the request, registers rdata for beat 0, and sets rvalid=1 in the next cycle (AR-to-R latency of 1).
- Read FSM, R_DATA: rvalid, rdata, rresp and rlast hold until rready. Each handshake loads the next beat with no bubble. rlast=1 when beat count equals arlen. After the last handshake: rvalid=0, rlast=0, back to R_IDLE.
- Read responses: an out-of-range beat gives rdata=0 and rresp=DECERR. An illegal burst gives rdata=0 and rresp=SLVERR on every beat.
- Simultaneous read and write to the same word: the read capture sees the array value from before that clock edge.
- Handshakes: stalled valid outputs never drop and their payload never changes until accepted. The AW and AR channels are independent and may complete in the same cycle.

Test Plan:
- INCR write at awaddr=0x10, awlen=3, data 0xA0..0xA3 with all strobes, then an INCR read at 0x10, len 3 -> bresp=00; rdata A0,A1,A2,A3, rresp=00, rlast only on beat 4.
- WRAP read at araddr=0x18, arlen=3 after the writes above (words 0x10..0x1C) -> address order 0x18,0x1C,0x10,0x14; rdata A2,A3,A0,A1. Same read with arlen=2 -> SLVERR on all 3 beats.
- Write 0x11223344 with wstrb=4'b0101 over a word holding 0xFFFFFFFF; wlast asserted early on beat 0 of an awlen=1 burst -> word reads 0xFF22FF44 and the early-wlast burst returns bresp=10. Hold bready=0 for 5 cycles -> bvalid and bid stable throughout.
- awaddr=MEM_DEPTH*4-4, awlen=1 -> first beat written, second dropped, bresp=11. Assert aresetn low during an rready=0 stall -> rvalid=0 and arready=1 asynchronously, with no further R beats.
